// File: rtl/sda_xfer_master.sv
// Purpose : master side of a single-wire turnaround link. It sends a word MSB first, releases sda, then collects the echoed word LSB first.
// Latency : done pulses 2*DATA_W+RX_LAT clocks after the accepting edge; busy is high for those same clocks.
// Backpr. : start is accepted only in IDLE or DONE. A start while busy is dropped and is not queued.
//
// Ports   : clk, rst_n (async, active-low) | start, tx_data (host request)
//           busy, done, rx_data (host result) | oe, sda (line to the peer)
//           mismatch (loopback compare result)
// Option  : define SDA_XFER_LOOPCHK_EN to compare the returned word against the sent word.
//           When the macro is undefined, mismatch is tied to 0.
module sda_xfer_master #(
    parameter int DATA_W = 8,
    parameter int RX_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              oe,
    inout  wire               sda,
    output logic              mismatch
);

    // One counter is shared by the TX, TURN and RX phases.
    // It must hold values up to max(DATA_W, RX_LAT) - 1.
    localparam int CNT_M = (DATA_W > RX_LAT) ? DATA_W : RX_LAT;
    localparam int CNT_W = $clog2(CNT_M);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_TURN,
        ST_RX,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  txsh_q, txsh_d;
    logic [DATA_W-1:0]  rxsh_q, rxsh_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               sda_q, sda_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic               word_last;
    logic               turn_last;

    assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign word_last = (cnt_q == CNT_W'(DATA_W - 1));
    assign turn_last = (cnt_q == CNT_W'(RX_LAT - 1));

    // Drive the line only while we own it.
    assign sda = oe_q ? 1'bz : sda_q;

    // ---------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            sda_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txsh_q  <= txsh_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = accept ? ST_TX : ST_IDLE;
            ST_TX:            if (word_last) state_d = ST_TURN;
            ST_TURN:          if (turn_last) state_d = ST_RX;
            ST_RX:            if (word_last) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Next values for the registered outputs and the datapath
    // ---------------------------------------------------------------
`ifdef SDA_XFER_LOOPCHK_EN
    logic mis_q, mis_d;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        txsh_d = txsh_q;
        rxsh_d = rxsh_q;
        rx_d   = rx_q;
        sda_d  = sda_q;
        oe_d   = oe_q;
        busy_d = busy_q;
        done_d = 1'b0;
`ifdef SDA_XFER_LOOPCHK_EN
        mis_d  = mis_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                oe_d  = 1'b0;
                sda_d = 1'b0;
                if (accept) begin
                    txsh_d = tx_data;
                    sda_d  = tx_data[DATA_W-1];
                    busy_d = 1'b1;
                    cnt_d  = '0;
`ifdef SDA_XFER_LOOPCHK_EN
                    mis_d  = 1'b0;
`endif
                end
            end
            ST_TX: begin
                // The word is rotated rather than shifted.
                // After DATA_W rotations it is back to the word that was sent,
                // so the loopback compare needs no second copy.
                txsh_d = {txsh_q[DATA_W-2:0], txsh_q[DATA_W-1]};
                if (word_last) begin
                    oe_d  = 1'b1;
                    sda_d = 1'b0;
                    cnt_d = '0;
                end else begin
                    sda_d = txsh_q[DATA_W-2];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TURN: begin
                cnt_d = turn_last ? '0 : cnt_q + CNT_W'(1);
            end
            ST_RX: begin
                // Bits arrive LSB first and are shifted in from the top.
                // After DATA_W samples the first sample sits in bit 0.
                rxsh_d = {sda, rxsh_q[DATA_W-1:1]};
                if (word_last) begin
                    rx_d   = rxsh_d;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    oe_d   = 1'b0;
                    sda_d  = 1'b0;
                    cnt_d  = '0;
`ifdef SDA_XFER_LOOPCHK_EN
                    mis_d  = (rxsh_d != txsh_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                oe_d   = 1'b0;
                sda_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

`ifdef SDA_XFER_LOOPCHK_EN
    // Sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
    assign mismatch = mis_q;
`else
    assign mismatch = 1'b0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign oe      = oe_q;

endmodule

// File: tb/tb_sda_xfer_master.sv
module tb_sda_xfer_master;

    localparam int DW  = 8;
    localparam int RL  = 1;
    localparam int LEN = 2*DW + RL;   // accepting edge to done edge

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          busy, done, oe, mismatch;
    logic [DW-1:0] rx_data;
    wire           sda;

    sda_xfer_master #(.DATA_W(DW), .RX_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data), .oe(oe),
        .sda(sda), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    typedef struct {
        logic [DW-1:0] word;
        int            done_edge;
        bit            mis;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            errors = 0;
    int            ec = 0;            // posedges seen so far
    int            last_acc = -1000;  // edge of the last accepted start
    logic [DW-1:0] last_tx = '0;
    int            free_edge = 0;     // earliest edge a new start is accepted
    bit            mis_model = 1'b0;
    logic [DW-1:0] rx_model = '0;
    logic [DW-1:0] fault_mask = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ec);
        end
    endtask

    // ---------------- peer: capture while master drives, echo after turnaround ----------------
    logic [DW-1:0] cap = '0;
    logic [DW-1:0] echo;
    int            pc = 0;
    logic          peer_bit = 1'b0;

    assign sda = oe ? peer_bit : 1'bz;

    initial begin
        forever begin
            @(negedge clk);
            if (busy && !oe) cap = {cap[DW-2:0], sda};
            if (oe) pc = pc + 1;
            else    pc = 0;
            echo = cap ^ fault_mask;
            if (pc - 1 - RL >= 0 && pc - 1 - RL < DW) peer_bit = echo[3'(pc - 1 - RL)];
            else                                      peer_bit = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        int   n;
        bit   in_tx, eb, eo;
        exp_t e;
        forever begin
            @(posedge clk);
            ec = ec + 1;
            #1;
            if (rst_n) begin
                n     = ec;
                in_tx = (n >= last_acc) && (n < last_acc + DW);
                eb    = (n >= last_acc) && (n < last_acc + LEN);
                eo    = (n >= last_acc + DW) && (n < last_acc + LEN);
                chk("busy", 32'(busy), 32'(eb));
                chk("oe", 32'(oe), 32'(eo));
                if (in_tx)    chk("sda_tx", 32'(sda), 32'(last_tx[3'(DW - 1 - (n - last_acc))]));
                else if (!eo) chk("sda_idle", 32'(sda), 32'(0));
                if (n == last_acc) mis_model = 1'b0;
                if (done) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL spurious_done: got done=1 expected done=0 (edge %0d)", n);
                    end else begin
                        e = sb.pop_front();
                        chk("done_edge", 32'(n), 32'(e.done_edge));
                        chk("rx_data", 32'(rx_data), 32'(e.word));
                        rx_model  = e.word;
                        mis_model = e.mis;
                    end
                end else if (sb.size() > 0 && sb[0].done_edge <= n) begin
                    vectors++;
                    errors++;
                    $display("FAIL missing_done: got done=0 expected done=1 (edge %0d)", n);
                    e = sb.pop_front();
                end
                chk("rx_hold", 32'(rx_data), 32'(rx_model));
                chk("mismatch", 32'(mismatch), 32'(mis_model));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Step forward to the negedge just before the given edge.
    // Always advances at least one negedge.
    task automatic wait_before(input int target);
        do @(negedge clk); while (ec + 1 < target);
    endtask

    // Call at a negedge. Drives start for one edge and applies the model's acceptance rule.
    task automatic drive_start(input logic [DW-1:0] d);
        exp_t e;
        start   = 1'b1;
        tx_data = d;
        if (ec + 1 >= free_edge) begin
            last_acc    = ec + 1;
            last_tx     = d;
            free_edge   = ec + 1 + LEN + 1;
            e.word      = d ^ fault_mask;
            e.done_edge = ec + 1 + LEN;
`ifdef SDA_XFER_LOOPCHK_EN
            e.mis       = (fault_mask != '0);
`else
            e.mis       = 1'b0;
`endif
            sb.push_back(e);
        end
        @(negedge clk);
        start   = 1'b0;
        tx_data = DW'($urandom);
    endtask

    task automatic model_reset();
        sb.delete();
        last_acc  = -1000;
        free_edge = 0;
        mis_model = 1'b0;
        rx_model  = '0;
    endtask

    initial begin
        int e0, g;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_oe", 32'(oe), 32'(0));
        chk("rst_rx", 32'(rx_data), 32'(0));
        chk("rst_sda", 32'(sda), 32'(0));
        chk("rst_mis", 32'(mismatch), 32'(0));
        rst_n = 1'b1;

        // Single transfer.
        wait_before(ec + 2);
        drive_start(8'h9D);
        wait_before(free_edge);

        // Back-to-back: the second start is driven in the DONE cycle.
        drive_start(8'h3C);
        wait_before(free_edge);
        drive_start(8'hA5);

        // A start while busy is ignored.
        wait_before(free_edge);
        drive_start(8'h12);
        wait_before(last_acc + 5);
        drive_start(8'hFF);
        wait_before(free_edge);

        // Reset during RX aborts the transfer with no done pulse.
        drive_start(8'h55);
        e0 = last_acc;
        wait_before(e0 + 12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(oe), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_rx", 32'(rx_data), 32'(0));
        chk("arst_sda", 32'(sda), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_before(ec + 2);
        drive_start(8'h0F);
        wait_before(free_edge);

        // The line flips returned bit 3.
        fault_mask = 8'h08;
        drive_start(8'h00);
        wait_before(free_edge);
        wait_before(ec + 2);
        fault_mask = 8'h00;
        drive_start(8'h6B);
        wait_before(free_edge);

        // Random traffic: back-to-back, idle gaps, and starts while busy.
        for (int i = 0; i < 40; i++) begin
            g = int'($urandom_range(0, 3));
            case (g)
                0:       wait_before(free_edge);
                1:       wait_before(free_edge + int'($urandom_range(1, 5)));
                2:       wait_before(ec + 1 + int'($urandom_range(1, 12)));
                default: wait_before(free_edge + int'($urandom_range(0, 2)));
            endcase
            drive_start(DW'($urandom));
        end

        wait_before(free_edge);
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_done: got %0d outstanding transfers, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
